// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide sequencing controller: start pulse, decode stall, single writeback
module md_sched #(
  parameter int MAX_CYCLES  = 40,
  parameter int RSTATUS_REG = 30,
  parameter int MUL_EXC     = 4,
  parameter int DIV_EXC     = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic        md_rdy,
  input  logic        md_exc,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic        wb_status,
  output logic [31:0] wb_status_val,
  output logic        squash
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_WB} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_kind;
  logic [4:0]    r_rd;
  logic          r_exc;

  logic w_det;
  logic w_wb;

  assign w_det = op_valid & (opcode == 5'b00000) &
                 ((alu_op == 5'b00110) | (alu_op == 5'b00111));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_kind  <= 1'b0;
      r_rd    <= '0;
      r_exc   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_det) begin
            r_kind  <= alu_op[0];
            r_rd    <= rd;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_exc   <= 1'b0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
          // Results arriving in START are dropped; only BUSY listens to md_rdy
          if (md_rdy) begin
            r_exc   <= md_exc;
            r_state <= S_WB;
          end else if (r_cnt == CNT_LAST) begin
            r_exc   <= 1'b1;
            r_state <= S_WB;
          end
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wb = (r_state == S_WB);

  assign ctrl_mult     = (r_state == S_START) & ~r_kind;
  assign ctrl_div      = (r_state == S_START) &  r_kind;
  // Stall is the only output allowed to see decode inputs; gate it so reset clears it
  assign stall         = reset & (((r_state == S_IDLE) & w_det) |
                                  (r_state == S_START) | (r_state == S_BUSY));
  assign squash        = w_wb;
  assign wb_status     = w_wb & r_exc;
  assign wb_en         = w_wb & (r_exc | (r_rd != 5'd0));
  assign wb_reg        = !w_wb ? 5'd0 : (r_exc ? 5'(RSTATUS_REG) : r_rd);
  assign wb_status_val = (w_wb & r_exc) ? (r_kind ? 32'(DIV_EXC) : 32'(MUL_EXC)) : 32'd0;

endmodule
